parity_frame_checker: RTL and testbench



---
 rtl/parity_pkg.sv | 21 ++
 rtl/parity_reduce.sv | 11 +
 rtl/parity_frame_checker.sv | 124 ++++++++++++
 tb/tb_parity_frame_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the frame parity checker and related link blocks.
package parity_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Bits needed to count 0..frame_len beats.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  // Increment that holds at the all-ones value of a cnt_w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int cnt_w);
    logic [31:0] max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one beat; shared with the transmit-side generator.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_checker.sv
// Running frame parity over WIDTH-bit beats; closes frames on FRAME_LEN beats or in_last,
// reports frame parity / pass flag and keeps a saturating bad-frame count.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  parameter int CNT_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           parity_out,
  output logic [cnt_width(FRAME_LEN)-1:0] beat_cnt,
  output logic                           frame_done,
  output logic                           frame_parity,
  output logic                           frame_ok,
  output logic [CNT_W-1:0]               err_cnt,
  output logic                           state_dbg
);

  localparam int   BW      = cnt_width(FRAME_LEN);
  localparam logic ODD_BIT = 1'(ODD);

  state_e         state_q, state_d;
  logic           parity_q, parity_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           fpar_q, fpar_d;
  logic           fok_q, fok_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic beat_p;
  logic acc;
  logic do_close;

  parity_reduce #(.WIDTH(WIDTH)) u_reduce (
    .data_i   (in_data),
    .parity_o (beat_p)
  );

  // In IDLE parity_q is 0, so acc equals the beat parity for a single-beat frame.
  assign acc = parity_q ^ beat_p;

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    fpar_d   = fpar_q;
    fok_d    = fok_q;
    err_d    = err_q;
    do_close = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_last || FRAME_LEN == 1) begin
            do_close = 1'b1;
          end else begin
            state_d  = ACCUM;
            parity_d = beat_p;
            cnt_d    = BW'(1);
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if ((int'(cnt_q) + 1 == FRAME_LEN) || in_last) begin
            do_close = 1'b1;
          end else begin
            parity_d = acc;
            cnt_d    = cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_close) begin
      state_d  = IDLE;
      parity_d = 1'b0;
      cnt_d    = '0;
      done_d   = 1'b1;
      fpar_d   = acc;
      fok_d    = (acc == ODD_BIT);
      if (acc != ODD_BIT) begin
        err_d = CNT_W'(sat_inc(32'(err_q), CNT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      fpar_q   <= 1'b0;
      fok_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      fpar_q   <= fpar_d;
      fok_q    <= fok_d;
      err_q    <= err_d;
    end
  end

  assign parity_out   = parity_q;
  assign beat_cnt     = cnt_q;
  assign frame_done   = done_q;
  assign frame_parity = fpar_q;
  assign frame_ok     = fok_q;
  assign err_cnt      = err_q;
  assign state_dbg    = (state_q == ACCUM);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker (WIDTH=8, FRAME_LEN=4, ODD=0, CNT_W=4): directed
// scenarios plus randomized traffic against a frame-level reference model.
module tb_parity_frame_checker;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int ODD       = 0;
  localparam int CNT_W     = 4;
  localparam int ERR_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             parity_out;
  logic [2:0]       beat_cnt;
  logic             frame_done;
  logic             frame_parity;
  logic             frame_ok;
  logic [CNT_W-1:0] err_cnt;
  logic             state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the open frame is a list of beats; the rest is derived from it.
  logic [WIDTH-1:0] exp_q[$];
  logic       exp_parity;
  int         exp_cnt;
  logic       exp_done;
  logic       exp_fp;
  logic       exp_ok;
  int         exp_err;

  parity_frame_checker #(
    .WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ODD(ODD), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .parity_out   (parity_out),
    .beat_cnt     (beat_cnt),
    .frame_done   (frame_done),
    .frame_parity (frame_parity),
    .frame_ok     (frame_ok),
    .err_cnt      (err_cnt),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic ones_parity(input int ones);
    return logic'(ones % 2);
  endfunction

  // Drive one cycle, let the edge pass, then advance the model to match.
  task automatic drive(input logic rst, input logic v, input logic [WIDTH-1:0] d, input logic l);
    int ones;
    reset = rst; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_done = 1'b0; exp_fp = 1'b0; exp_ok = 1'b0; exp_err = 0;
    end else begin
      exp_done = 1'b0;
      if (v) begin
        exp_q.push_back(d);
        if (exp_q.size() == FRAME_LEN || l) begin
          ones = 0;
          foreach (exp_q[i]) ones += $countones(exp_q[i]);
          exp_fp   = ones_parity(ones);
          exp_ok   = (exp_fp == logic'(ODD));
          exp_done = 1'b1;
          if (!exp_ok && exp_err < ERR_MAX) exp_err++;
          exp_q.delete();
        end
      end
    end
    ones = 0;
    foreach (exp_q[i]) ones += $countones(exp_q[i]);
    exp_parity = ones_parity(ones);
    exp_cnt    = exp_q.size();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 8'hFF, 1'b0);
      n_vec++;
      if ({parity_out, beat_cnt, frame_done, frame_parity, frame_ok, err_cnt} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got po=%b cnt=%0d done=%b fp=%b ok=%b err=%0d, want all 0",
                 c, parity_out, beat_cnt, frame_done, frame_parity, frame_ok, err_cnt);
      end
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] beats [4];
    logic       want_po [4];
    int         want_cnt [4];
    logic       want_done [4];
    beats = '{8'h01, 8'h03, 8'h00, 8'h01};
    want_po = '{1'b1, 1'b1, 1'b1, 1'b0};
    want_cnt = '{1, 2, 3, 0};
    want_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, beats[i], 1'b0);
      n_vec++;
      if (parity_out !== want_po[i] || int'(beat_cnt) != want_cnt[i] || frame_done !== want_done[i]) begin
        n_err++;
        $display("FAIL good_frame beat %0d: got po=%b cnt=%0d done=%b, want po=%b cnt=%0d done=%b",
                 i, parity_out, beat_cnt, frame_done, want_po[i], want_cnt[i], want_done[i]);
      end
    end
    n_vec++;
    if (frame_parity !== 1'b0 || frame_ok !== 1'b1 || err_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL good_frame_result: got fp=%b ok=%b err=%0d, want fp=0 ok=1 err=0",
               frame_parity, frame_ok, err_cnt);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    n_vec++;
    if (frame_done !== 1'b0 || frame_ok !== 1'b1) begin
      n_err++;
      $display("FAIL good_frame_pulse: got done=%b ok=%b, want done=0 ok=1", frame_done, frame_ok);
    end
  endtask

  task automatic test_bad_frame_gaps();
    logic [7:0] beats [4];
    int         pulses;
    beats = '{8'h07, 8'h00, 8'h00, 8'h00};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, beats[i], 1'b0);
      if (frame_done) pulses++;
      for (int g = 0; g < 1 + (i % 3); g++) begin
        drive(1'b0, 1'b0, 8'hA5, 1'b1);
        if (frame_done) pulses++;
      end
    end
    n_vec++;
    if (pulses != 1 || frame_parity !== 1'b1 || frame_ok !== 1'b0 || err_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL bad_frame_gaps: got pulses=%0d fp=%b ok=%b err=%0d, want pulses=1 fp=1 ok=0 err=1",
               pulses, frame_parity, frame_ok, err_cnt);
    end
  endtask

  task automatic test_short_frame();
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    n_vec++;
    if (frame_done !== 1'b1 || frame_ok !== 1'b0 || frame_parity !== 1'b1 || err_cnt !== 4'd2
        || beat_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL short_frame: got done=%b ok=%b fp=%b err=%0d cnt=%0d, want done=1 ok=0 fp=1 err=2 cnt=0",
               frame_done, frame_ok, frame_parity, err_cnt, beat_cnt);
    end
    drive(1'b0, 1'b1, 8'h03, 1'b0);
    n_vec++;
    if (parity_out !== 1'b0 || beat_cnt !== 3'd1 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back: got po=%b cnt=%0d done=%b, want po=0 cnt=1 done=0",
               parity_out, beat_cnt, frame_done);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] beats [4];
    int         want;
    beats = '{8'h01, 8'h00, 8'h00, 8'h00};
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int f = 1; f <= 17; f++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, beats[i], 1'b0);
      want = (f < ERR_MAX) ? f : ERR_MAX;
      if (f >= 14) begin
        n_vec++;
        if (int'(err_cnt) != want || frame_done !== 1'b1) begin
          n_err++;
          $display("FAIL saturation frame %0d: got err=%0d done=%b, want err=%0d done=1",
                   f, err_cnt, frame_done, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] beats [4];
    int         pulses;
    beats = '{8'h01, 8'h00, 8'h00, 8'h00};
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 1'b1);
    n_vec++;
    if ({parity_out, beat_cnt, frame_done, frame_parity, frame_ok, err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got po=%b cnt=%0d done=%b fp=%b ok=%b err=%0d, want all 0",
               parity_out, beat_cnt, frame_done, frame_parity, frame_ok, err_cnt);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, beats[i], 1'b0);
      if (frame_done) pulses++;
    end
    n_vec++;
    if (pulses != 1 || frame_ok !== 1'b0 || err_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL after_mid_reset: got pulses=%0d ok=%b err=%0d, want pulses=1 ok=0 err=1",
               pulses, frame_ok, err_cnt);
    end
  endtask

  task automatic test_random();
    logic v, l, r;
    logic [7:0] d;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      d = 8'($urandom);
      drive(r, v, d, l);
      n_vec++;
      if (parity_out !== exp_parity || int'(beat_cnt) != exp_cnt || frame_done !== exp_done
          || frame_parity !== exp_fp || frame_ok !== exp_ok || int'(err_cnt) != exp_err
          || state_dbg !== (exp_cnt != 0)) begin
        n_err++;
        $display("FAIL random cycle %0d: got po=%b cnt=%0d done=%b fp=%b ok=%b err=%0d st=%b, want po=%b cnt=%0d done=%b fp=%b ok=%b err=%0d st=%b",
                 c, parity_out, beat_cnt, frame_done, frame_parity, frame_ok, err_cnt, state_dbg,
                 exp_parity, exp_cnt, exp_done, exp_fp, exp_ok, exp_err, (exp_cnt != 0));
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_frame_gaps();
    test_short_frame();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
